// File: rtl/conv3x3_stream_engine_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv3x3_stream_engine_if
// Function : Pixel-in / result-out valid-ready streams of the 3x3 conv engine.
// Revision : 1.0
// ============================================================================
interface conv3x3_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_stream_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv3x3_stream_engine
// Function : Streaming 3x3 valid convolution with line buffers and loadable
//            coefficients; 4-stage pipeline, saturating shifted output.
// Revision : 1.0
// ============================================================================
module conv3x3_stream_engine #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              coef_we,
  input  wire logic [3:0]        coef_addr,
  input  wire logic [COEF_W-1:0] coef_data,
  conv3x3_stream_engine_if.slave s,
  output logic                   busy,
  output logic                   done
);
  localparam int c_ROW_W  = $clog2(IMG_H);
  localparam int c_COL_W  = $clog2(IMG_W);
  localparam int c_PROD_W = DATA_W + COEF_W;
  localparam int c_PART_W = c_PROD_W + 2;
  localparam int c_SUM_W  = c_PROD_W + 4;
  localparam int c_WIDE_W = ((c_SUM_W > OUT_W) ? c_SUM_W : OUT_W) + 1;
  localparam logic [c_WIDE_W-1:0] c_MAX = (c_WIDE_W'(1) << OUT_W) - c_WIDE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [COEF_W-1:0]   r_coef [0:8];
  logic [DATA_W-1:0]   r_lb0  [0:IMG_W-1];
  logic [DATA_W-1:0]   r_lb1  [0:IMG_W-1];
  logic [DATA_W-1:0]   r_win  [0:8];
  logic [c_PROD_W-1:0] r_prod [0:8];
  logic [c_PART_W-1:0] r_part [0:2];

  logic               r_s1_v, r_s2_v, r_s3_v, r_out_v;
  logic [c_ROW_W-1:0] r_s1_row, r_s2_row, r_s3_row, r_out_row;
  logic [c_COL_W-1:0] r_s1_col, r_s2_col, r_s3_col, r_out_col;
  logic [OUT_W-1:0]   r_out_data;

  logic                w_stall, w_in_ready, w_accept, w_last_px, w_win_close, w_pipe_empty;
  logic [c_SUM_W-1:0]  w_sum;
  logic [c_WIDE_W-1:0] w_wide;
  logic [OUT_W-1:0]    w_result;

  assign w_stall      = r_out_v & ~s.out_ready;
  assign w_in_ready   = (r_state == ST_STREAM) & ~w_stall;
  assign w_accept     = s.in_valid & w_in_ready;
  assign w_last_px    = w_accept & (r_col == c_COL_W'(IMG_W - 1)) & (r_row == c_ROW_W'(IMG_H - 1));
  assign w_win_close  = w_accept & (r_row >= c_ROW_W'(2)) & (r_col >= c_COL_W'(2));
  assign w_pipe_empty = ~r_s1_v & ~r_s2_v & ~r_s3_v & (~r_out_v | s.out_ready);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start)        w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_last_px)    w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (w_pipe_empty) w_state_nxt = ST_DONE;
      ST_DONE:                     w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      for (int i = 0; i < 9; i++) r_coef[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        for (int i = 0; i < 9; i++)
          if (coef_we && (coef_addr == 4'(i))) r_coef[i] <= coef_data;
        if (start) begin
          r_col <= '0;
          r_row <= '0;
        end
      end else if (w_accept) begin
        if (r_col == c_COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  // Line buffers, window and arithmetic carry no reset: every entry is written
  // in a frame before it can reach a valid result.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= s.in_data;
      for (int i = 0; i < 3; i++) begin
        r_win[3*i]   <= r_win[3*i+1];
        r_win[3*i+1] <= r_win[3*i+2];
      end
      r_win[2] <= r_lb1[r_col];
      r_win[5] <= r_lb0[r_col];
      r_win[8] <= s.in_data;
    end
    if (!w_stall) begin
      for (int i = 0; i < 9; i++)
        r_prod[i] <= c_PROD_W'(r_win[i]) * c_PROD_W'(r_coef[i]);
      for (int i = 0; i < 3; i++)
        r_part[i] <= c_PART_W'(r_prod[3*i]) + c_PART_W'(r_prod[3*i+1]) + c_PART_W'(r_prod[3*i+2]);
    end
  end

  assign w_sum    = c_SUM_W'(r_part[0]) + c_SUM_W'(r_part[1]) + c_SUM_W'(r_part[2]);
  assign w_wide   = c_WIDE_W'(w_sum) >> OUT_SHIFT;
  assign w_result = (w_wide > c_MAX) ? c_MAX[OUT_W-1:0] : w_wide[OUT_W-1:0];

  // A held output freezes every stage so nothing is dropped or duplicated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s3_v     <= 1'b0;
      r_out_v    <= 1'b0;
      r_s1_row   <= '0;
      r_s2_row   <= '0;
      r_s3_row   <= '0;
      r_out_row  <= '0;
      r_s1_col   <= '0;
      r_s2_col   <= '0;
      r_s3_col   <= '0;
      r_out_col  <= '0;
      r_out_data <= '0;
    end else if (!w_stall) begin
      r_s1_v   <= w_win_close;
      r_s1_row <= r_row - c_ROW_W'(2);
      r_s1_col <= r_col - c_COL_W'(2);
      r_s2_v   <= r_s1_v;
      r_s2_row <= r_s1_row;
      r_s2_col <= r_s1_col;
      r_s3_v   <= r_s2_v;
      r_s3_row <= r_s2_row;
      r_s3_col <= r_s2_col;
      r_out_v  <= r_s3_v;
      if (r_s3_v) begin
        r_out_data <= w_result;
        r_out_row  <= r_s3_row;
        r_out_col  <= r_s3_col;
      end
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_v;
  assign s.out_data  = r_out_data;
  assign s.out_row   = r_out_row;
  assign s.out_col   = r_out_col;
  assign busy        = (r_state == ST_STREAM) | (r_state == ST_FLUSH);
  assign done        = (r_state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv3x3_stream_engine
// Function : Randomised frame bench with a window-sum reference model.
// Revision : 1.0
// ============================================================================
module tb_conv3x3_stream_engine;
  localparam int IMG_W = 5, IMG_H = 6, DATA_W = 8, COEF_W = 8, OUT_W = 12, OUT_SHIFT = 2;
  localparam int ROW_W = $clog2(IMG_H), COL_W = $clog2(IMG_W);
  localparam int NPIX = IMG_W * IMG_H;
  localparam longint SAT = (64'd1 << OUT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic busy, done;

  conv3x3_stream_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ROW_W(ROW_W), .COL_W(COL_W)) s ();

  conv3x3_stream_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .COEF_W(COEF_W),
                          .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .s(s), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pix [IMG_H][IMG_W];
  int m_coef [9];
  typedef struct { longint d; int r; int c; } exp_t;
  exp_t exp_q [$];

  bit prev_stall = 0, first_seen = 0;
  longint prev_pk = 0, first_data = 0;
  int first_cyc = 0, acc_cyc = -1, done_cnt = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Output (R,C) is the coefficient-weighted sum of pixels (R..R+2, C..C+2).
  function automatic longint ref_out(input int R, input int C);
    longint sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += longint'(m_coef[3*i+j]) * longint'(pix[R+i][C+j]);
    sum = sum >> OUT_SHIFT;
    return (sum > SAT) ? SAT : sum;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      longint pk;
      pk = longint'({s.out_data, s.out_row, s.out_col});
      if (prev_stall) begin
        chk(s.out_valid, "hold_valid", longint'(s.out_valid), 1);
        chk(pk == prev_pk, "hold_payload", pk, prev_pk);
      end
      if (s.out_valid && !s.out_ready)
        chk(!s.in_ready, "stall_in_ready", longint'(s.in_ready), 0);
      if (s.out_valid && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
        first_data = longint'(s.out_data);
      end
      if (s.out_valid && s.out_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "extra_result", pk, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(longint'(s.out_data) == e.d, "out_data", longint'(s.out_data), e.d);
          chk(int'(s.out_row) == e.r && int'(s.out_col) == e.c, "out_pos",
              longint'(s.out_row) * 100 + longint'(s.out_col), longint'(e.r * 100 + e.c));
        end
      end
      if (done) begin
        done_cnt++;
        chk(exp_q.size() == 0, "done_early", longint'(exp_q.size()), 0);
      end
      prev_stall = s.out_valid && !s.out_ready;
      prev_pk    = pk;
    end
  end

  task automatic chk_zero(input string tag);
    chk(s.in_ready == 0,  {tag, "_in_ready"},  longint'(s.in_ready), 0);
    chk(s.out_valid == 0, {tag, "_out_valid"}, longint'(s.out_valid), 0);
    chk(busy == 0,        {tag, "_busy"},      longint'(busy), 0);
    chk(done == 0,        {tag, "_done"},      longint'(done), 0);
    chk({s.out_data, s.out_row, s.out_col} == '0, {tag, "_payload"},
        longint'({s.out_data, s.out_row, s.out_col}), 0);
  endtask

  task automatic load_coefs();
    for (int a = 0; a < 16; a++) begin
      @(posedge clk); #1;
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_data = (a < 9) ? COEF_W'(m_coef[a]) : COEF_W'($urandom);
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic fill_pix(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (mode)
          0:       pix[r][c] = int'($urandom_range(0, 255));
          1:       pix[r][c] = int'($urandom_range(0, 15));
          2:       pix[r][c] = r * IMG_W + c;
          3:       pix[r][c] = 255;
          default: pix[r][c] = 1;
        endcase
  endtask

  task automatic run_frame(input int vpct, input int rpct, input bit stall_win, input bit inject,
                           input bit cw_start, input int abort_at, output bit aborted);
    int idx = 0;
    bit fin = 0;
    aborted = 0;
    if (cw_start) m_coef[8] = int'($urandom_range(0, 255));
    exp_q.delete();
    for (int r = 0; r < IMG_H - 2; r++)
      for (int c = 0; c < IMG_W - 2; c++)
        exp_q.push_back('{ref_out(r, c), r, c});
    done_cnt = 0; first_seen = 0; acc_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    if (cw_start) begin
      coef_we = 1'b1; coef_addr = 4'd8; coef_data = COEF_W'(m_coef[8]);
    end
    @(posedge clk); #1;
    start = 1'b0; coef_we = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      s.in_valid  = (idx < NPIX) && ($urandom_range(0, 99) < vpct);
      s.in_data   = (idx < NPIX) ? DATA_W'(pix[idx / IMG_W][idx % IMG_W]) : '0;
      s.out_ready = (stall_win && t >= 18 && t < 28) ? 1'b0 : ($urandom_range(0, 99) < rpct);
      if (inject) begin
        start = (t == 5); coef_we = (t == 5); coef_addr = 4'd4; coef_data = 8'd7;
      end
      @(negedge clk);
      if (t == 0) chk(busy == 1, "busy_stream", longint'(busy), 1);
      if (s.in_valid && s.in_ready) begin
        if (idx == 2 * IMG_W + 2) acc_cyc = cyc;
        idx++;
      end
      if (done) begin
        fin = 1;
      end else if (abort_at != 0 && idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        s.in_valid = 1'b0; start = 1'b0; coef_we = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 9; i++) m_coef[i] = 0;
        aborted = 1;
        return;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    s.in_valid = 1'b0; start = 1'b0; coef_we = 1'b0; s.out_ready = 1'b1;
    if (!fin) begin
      chk(0, "frame_timeout", longint'(exp_q.size()), 0);
    end else begin
      repeat (3) @(negedge clk);
      chk(done_cnt == 1, "done_pulses", longint'(done_cnt), 1);
      chk(exp_q.size() == 0, "results_left", longint'(exp_q.size()), 0);
      chk(busy == 0, "busy_after", longint'(busy), 0);
      chk(s.in_ready == 0, "idle_in_ready", longint'(s.in_ready), 0);
    end
  endtask

  initial begin
    bit ab;
    s.in_valid = 1'b0; s.in_data = '0; s.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) m_coef[i] = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("in_reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // All ones: sum 9 shifted by 2 gives 2; also pins the 4-cycle latency.
    for (int i = 0; i < 9; i++) m_coef[i] = 1;
    load_coefs();
    fill_pix(4);
    chk(ref_out(0, 0) == 2, "model_pin_ones", ref_out(0, 0), 2);
    run_frame(100, 100, 0, 0, 0, 0, ab);
    chk(first_cyc - acc_cyc == 4, "latency", longint'(first_cyc - acc_cyc), 4);

    // Ramp with coefs 4: out = 9 * centre pixel; mid-stream coef write/start ignored.
    for (int i = 0; i < 9; i++) m_coef[i] = 4;
    load_coefs();
    fill_pix(2);
    chk(ref_out(0, 0) == 54, "model_pin_ramp00", ref_out(0, 0), 54);
    chk(ref_out(3, 2) == 207, "model_pin_ramp32", ref_out(3, 2), 207);
    run_frame(100, 100, 0, 1, 0, 0, ab);
    chk(first_data == 54, "first_ramp_result", first_data, 54);

    // Saturation with a 10-cycle forced stall.
    for (int i = 0; i < 9; i++) m_coef[i] = 255;
    load_coefs();
    fill_pix(3);
    chk(ref_out(1, 1) == SAT, "model_pin_sat", ref_out(1, 1), SAT);
    run_frame(70, 60, 1, 0, 0, 0, ab);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++)
        m_coef[i] = (f % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      load_coefs();
      fill_pix(f % 2);
      run_frame(int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), f == 1, 0, f == 2, 0, ab);
    end

    // Reset after 12 pixels; the next frame runs on reset (zero) coefficients.
    for (int i = 0; i < 9; i++) m_coef[i] = 1;
    load_coefs();
    fill_pix(4);
    run_frame(100, 100, 0, 0, 0, 12, ab);
    chk(ab, "abort_reached", longint'(ab), 1);
    @(negedge clk);
    chk(done_cnt == 0, "no_done_after_abort", longint'(done_cnt), 0);
    chk_zero("post_abort");
    fill_pix(0);
    run_frame(80, 80, 0, 0, 0, 0, ab);

    for (int i = 0; i < 9; i++) m_coef[i] = 1;
    load_coefs();
    fill_pix(4);
    run_frame(100, 100, 0, 0, 0, 0, ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
